// File: rtl/button_gesture_if.sv
// Button gesture interface: debounced level in, gesture event pulses and held flag out.
interface button_gesture_if;
   logic Level;
   logic Click;
   logic DoubleClick;
   logic LongPress;
   logic Held;
   logic Repeat;

   modport master (
      output Level,
      input  Click, DoubleClick, LongPress, Held, Repeat
   );

   modport slave (
      input  Level,
      output Click, DoubleClick, LongPress, Held, Repeat
   );
endinterface

// File: rtl/button_gesture.sv
// Button gesture classifier: turns a debounced level into click / double-click / long-press events.
// Optional auto-repeat while held is enabled by defining BUTTON_GESTURE_REPEAT_EN.
//
// state    | meaning
// IDLE     | no button activity, waiting for a press
// PRESS1   | first press in progress, timing towards long press
// WAIT2    | short press released, window open for a second press
// LONG     | long press held, Held high (optional Repeat pulses)
// WAIT_REL | ignore everything until the button is released
module button_gesture #(
   parameter int LONG_TICKS   = 8,
   parameter int DCLICK_TICKS = 6,
   parameter int REPEAT_TICKS = 4,
   parameter int CNT_W        = 20
) (
   input logic              Clk,
   input logic              Reset,
   button_gesture_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, LONG, WAIT_REL} state_t;

   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_TICKS - 1);

   if (LONG_TICKS < 1 || longint'(LONG_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_long
      $error("LONG_TICKS out of range");
   end
   if (DCLICK_TICKS < 1 || longint'(DCLICK_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_dclick
      $error("DCLICK_TICKS out of range");
   end
   if (REPEAT_TICKS < 1 || longint'(REPEAT_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_repeat
      $error("REPEAT_TICKS out of range");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic             long_tc, dclick_tc, rep_tc, rep_hit;
   logic             click_q, dbl_q, long_q, held_q, rep_q;
   logic             click_d, dbl_d, long_d, held_d, rep_d;

   assign long_tc   = (count == LONG_TC);
   assign dclick_tc = (count == DCLICK_TC);

`ifdef BUTTON_GESTURE_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);
   assign rep_tc = (count == REPEAT_TC);
`else
   assign rep_tc = 1'b0;
`endif

   assign rep_hit = (state == LONG) && bus.Level && rep_tc;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= WAIT_REL;
         count   <= '0;
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
         held_q  <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         click_q <= click_d;
         dbl_q   <= dbl_d;
         long_q  <= long_d;
         held_q  <= held_d;
         rep_q   <= rep_d;
      end
   end

   // Level is checked before counter expiry in every state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.Level) state_nxt = PRESS1;
         PRESS1:   if (!bus.Level) state_nxt = WAIT2;
                   else if (long_tc) state_nxt = LONG;
         WAIT2:    if (bus.Level) state_nxt = WAIT_REL;
                   else if (dclick_tc) state_nxt = IDLE;
         LONG:     if (!bus.Level) state_nxt = IDLE;
         WAIT_REL: if (!bus.Level) state_nxt = IDLE;
         default:  state_nxt = WAIT_REL;
      endcase
      count_nxt = ((state_nxt != state) || rep_hit) ? '0 : count + CNT_W'(1);
   end

   always_comb begin
      click_d = (state == WAIT2) && !bus.Level && dclick_tc;
      dbl_d   = (state == WAIT2) && bus.Level;
      long_d  = (state == PRESS1) && bus.Level && long_tc;
      held_d  = (state_nxt == LONG);
      rep_d   = rep_hit;
   end

   assign bus.Click       = click_q;
   assign bus.DoubleClick = dbl_q;
   assign bus.LongPress   = long_q;
   assign bus.Held        = held_q;
   assign bus.Repeat      = rep_q;

endmodule
